// File: rtl/sc_argmax_decoder_if.sv
// ---------------------------------------------------------------------------
// sc_argmax_decoder_if
// Bundle of the request/result signals of the stochastic argmax decoder.
//   start      : single-cycle request to begin a decode window
//   abort      : synchronous cancel of an in-progress decode
//   din[N]     : one stochastic bit per class
//   busy       : decoder is not idle
//   out_valid  : result valid
//   out_ready  : consumer accepts the result
//   class_idx  : winning class index
//   max_count  : ones-count of the winning class
// Modports: master drives requests and consumes results, slave is the decoder.
// ---------------------------------------------------------------------------
interface sc_argmax_decoder_if #(
  parameter int N  = 10,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
);
  logic          start;
  logic          abort;
  logic [N-1:0]  din;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] class_idx;
  logic [W:0]    max_count;

  modport master (
    output start, abort, din, out_ready,
    input  busy, out_valid, class_idx, max_count
  );

  modport slave (
    input  start, abort, din, out_ready,
    output busy, out_valid, class_idx, max_count
  );
endinterface

// File: rtl/sc_argmax_decoder.sv
// ---------------------------------------------------------------------------
// sc_argmax_decoder
// Counts ones on N stochastic class streams over a 2^W-cycle window, then
// scans the counters one per cycle to find the class with the highest count
// (ties go to the lowest index) and presents it with a valid/ready handshake.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : sc_argmax_decoder_if.slave (start/abort/din/out_ready in,
//           busy/out_valid/class_idx/max_count out)
// ---------------------------------------------------------------------------
module sc_argmax_decoder #(
  parameter int N  = 10,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  sc_argmax_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [W:0]    w_cnt [N];
  logic [W-1:0]  r_win;
  logic [IW-1:0] r_scan;
  logic [IW-1:0] r_best_idx;
  logic [W:0]    r_best_cnt;
  logic [IW-1:0] r_class_idx;
  logic [W:0]    r_max_count;
  logic [W:0]    w_cur_cnt;

  logic w_clear;
  logic w_accum_en;
  logic w_cmp_en;
  logic w_win_last;
  logic w_scan_last;
  logic w_take;
  logic w_busy;
  logic w_out_valid;

  assign w_win_last  = (r_win == {W{1'b1}});
  assign w_scan_last = (r_scan == IW'(N-1));

  // Counter currently under evaluation in COMPARE.
  always_comb begin
    w_cur_cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (r_scan == IW'(i)) w_cur_cnt = w_cnt[i];
    end
  end

  // Strictly greater keeps the earlier (lower) index on ties.
  assign w_take = (w_cur_cnt > r_best_cnt);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and control decode
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_accum_en   = 1'b0;
    w_cmp_en     = 1'b0;
    w_busy       = 1'b1;
    w_out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_clear      = 1'b1;
          w_state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.abort) begin
          w_state_next = IDLE;
        end else begin
          w_accum_en = 1'b1;
          if (w_win_last) w_state_next = COMPARE;
        end
      end
      COMPARE: begin
        if (bus.abort) begin
          w_state_next = IDLE;
        end else begin
          w_cmp_en = 1'b1;
          if (w_scan_last) w_state_next = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Per-class ones counters; W+1 bits so a full window of ones fits.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cnt
      logic [W:0] r_cnt;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)           r_cnt <= '0;
        else if (w_clear)    r_cnt <= '0;
        else if (w_accum_en) r_cnt <= r_cnt + (W+1)'(bus.din[gi]);
      end
      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  // Window counter, scan state and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win       <= '0;
      r_scan      <= '0;
      r_best_idx  <= '0;
      r_best_cnt  <= '0;
      r_class_idx <= '0;
      r_max_count <= '0;
    end else begin
      if (w_clear)         r_win <= '0;
      else if (w_accum_en) r_win <= r_win + 1'b1;

      if (w_accum_en && w_win_last) begin
        r_scan     <= '0;
        r_best_idx <= '0;
        r_best_cnt <= '0;
      end else if (w_cmp_en) begin
        if (w_take) begin
          r_best_cnt <= w_cur_cnt;
          r_best_idx <= r_scan;
        end
        r_scan <= r_scan + 1'b1;
        // The final counter is folded in directly so the result lands on DONE entry.
        if (w_scan_last) begin
          r_class_idx <= w_take ? r_scan    : r_best_idx;
          r_max_count <= w_take ? w_cur_cnt : r_best_cnt;
        end
      end
    end
  end

  assign bus.busy      = w_busy;
  assign bus.out_valid = w_out_valid;
  assign bus.class_idx = r_class_idx;
  assign bus.max_count = r_max_count;

endmodule

// File: tb/tb_sc_argmax_decoder.sv
// ---------------------------------------------------------------------------
// tb_sc_argmax_decoder
// Drives decode windows into a W=4 and a W=8 decoder (N=10). Expected
// results are computed from the driven din bits, pushed to a queue when the
// window ends and popped when out_valid appears.
// ---------------------------------------------------------------------------
module tb_sc_argmax_decoder;

  localparam int N = 10;

  typedef struct {
    int idx;
    int cnt;
  } exp_t;

  logic clk;
  logic reset;

  sc_argmax_decoder_if #(.N(N), .W(4)) u_if ();
  sc_argmax_decoder_if #(.N(N), .W(8)) u_if8 ();

  sc_argmax_decoder #(.N(N), .W(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  sc_argmax_decoder #(.N(N), .W(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  int   last_idx = 0;
  int   last_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] gen(input int p, input int k);
    logic [N-1:0] d;
    d = '0;
    case (p)
      0: d[3] = 1'b1;
      1: begin
        d[2] = (k < 12);
        d[7] = (k >= 4);
        d[0] = (k < 8);
        d[9] = k[0];
      end
      3: d = '1;
      4: begin
        d[5] = (k < 10);
        d[1] = (k < 3);
      end
      5: d = N'($urandom);
      default: d = '0;
    endcase
    return d;
  endfunction

  // Caller is just after a falling edge. Issues start, drives 16 din samples
  // and pushes the expected result unless aborted at sample abort_at.
  task automatic start_window(input int p, input int abort_at, input bit extra,
                              input bit abort_w_start, output bit aborted);
    int           cnts[N];
    logic [N-1:0] d;
    exp_t         e;
    bit           seen_valid;
    aborted = 1'b0;
    foreach (cnts[i]) cnts[i] = 0;
    u_if.start = 1'b1;
    u_if.abort = abort_w_start;
    u_if.din   = '0;
    @(negedge clk);
    check_val("accept_busy", u_if.busy, 1);
    for (int k = 0; k < 16; k++) begin
      d = gen(p, k);
      u_if.din   = d;
      u_if.start = extra && (k % 3 == 0);
      u_if.abort = (k == abort_at);
      for (int i = 0; i < N; i++) cnts[i] += int'(d[i]);
      @(negedge clk);
      if (k == abort_at) begin
        u_if.abort = 1'b0;
        u_if.start = 1'b0;
        u_if.din   = '0;
        aborted    = 1'b1;
        check_val("abort_busy", u_if.busy, 0);
        seen_valid = 1'b0;
        repeat (14) begin
          if (u_if.out_valid) seen_valid = 1'b1;
          @(negedge clk);
        end
        check_val("abort_no_valid", seen_valid, 0);
        return;
      end
    end
    u_if.din   = '0;
    u_if.start = 1'b0;
    e.idx = 0;
    e.cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (cnts[i] > e.cnt) begin
        e.cnt = cnts[i];
        e.idx = i;
      end
    end
    sb_q.push_back(e);
  endtask

  // Caller is just after the last sampling edge (edge 16).
  task automatic finish_window(input int hold);
    int   cyc;
    exp_t e;
    check_val("retain_in_compare", u_if.class_idx, last_idx);
    cyc = 0;
    while (!u_if.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_val("latency", 16 + cyc, 26);
    check_val("sb_depth", sb_q.size(), 1);
    if (!u_if.out_valid || sb_q.size() == 0) return;
    e = sb_q.pop_front();
    $display("result class_idx=%0d max_count=%0d (expected %0d/%0d)",
             u_if.class_idx, u_if.max_count, e.idx, e.cnt);
    check_val("class_idx", u_if.class_idx, e.idx);
    check_val("max_count", u_if.max_count, e.cnt);
    repeat (hold) begin
      @(negedge clk);
      check_val("hold_valid", u_if.out_valid, 1);
      check_val("hold_idx", u_if.class_idx, e.idx);
      check_val("hold_cnt", u_if.max_count, e.cnt);
    end
    u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.out_ready = 1'b0;
    check_val("drop_valid", u_if.out_valid, 0);
    check_val("idle_busy", u_if.busy, 0);
    check_val("retain_idle_cnt", u_if.max_count, e.cnt);
    last_idx = e.idx;
    last_cnt = e.cnt;
  endtask

  initial begin
    bit   ab;
    int   cyc;
    bit   seen;
    exp_t e;
    reset = 1'b1;
    u_if.start = 1'b0;  u_if.abort = 1'b0;  u_if.din = '0;  u_if.out_ready = 1'b0;
    u_if8.start = 1'b0; u_if8.abort = 1'b0; u_if8.din = '0; u_if8.out_ready = 1'b0;
    #3;
    check_val("rst_busy", u_if.busy, 0);
    check_val("rst_valid", u_if.out_valid, 0);
    check_val("rst_idx", u_if.class_idx, 0);
    check_val("rst_cnt", u_if.max_count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single constant-high class
    start_window(0, -1, 1'b0, 1'b0, ab);
    finish_window(0);

    // Tie between classes 2 and 7
    start_window(1, -1, 1'b0, 1'b0, ab);
    finish_window(0);

    // All zero, consumer stalls for 5 cycles
    start_window(2, -1, 1'b0, 1'b0, ab);
    finish_window(5);

    // Abort in IDLE has no effect
    u_if.abort = 1'b1;
    @(negedge clk);
    u_if.abort = 1'b0;
    check_val("idle_abort_busy", u_if.busy, 0);

    // Abort mid-window with all-ones data, then a fresh window
    start_window(3, 8, 1'b0, 1'b0, ab);
    check_val("abort_taken", ab, 1);
    start_window(4, -1, 1'b0, 1'b0, ab);
    finish_window(0);

    // start together with abort in IDLE: start wins
    start_window(5, -1, 1'b0, 1'b1, ab);
    finish_window(1);

    // Asynchronous reset between edges during COMPARE
    start_window(1, -1, 1'b0, 1'b0, ab);
    repeat (4) @(negedge clk);
    check_val("retain_mid_compare", u_if.max_count, last_cnt);
    #2 reset = 1'b1;
    #1;
    check_val("async_busy", u_if.busy, 0);
    check_val("async_valid", u_if.out_valid, 0);
    check_val("async_idx", u_if.class_idx, 0);
    check_val("async_cnt", u_if.max_count, 0);
    #1 reset = 1'b0;
    void'(sb_q.pop_back());
    last_idx = 0;
    last_cnt = 0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (u_if.out_valid || u_if.busy) seen = 1'b1;
    end
    check_val("post_reset_quiet", seen, 0);

    // Fresh window with extra start pulses during ACCUM
    start_window(5, -1, 1'b1, 1'b0, ab);
    finish_window(0);

    // W=8: full window of ones on class 9
    u_if8.start = 1'b1;
    @(negedge clk);
    u_if8.start = 1'b0;
    u_if8.din   = N'(1) << 9;
    repeat (256) @(negedge clk);
    u_if8.din = '0;
    e.idx = 9;
    e.cnt = 256;
    sb_q.push_back(e);
    cyc = 0;
    while (!u_if8.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_val("w8_latency", 256 + cyc, 266);
    check_val("w8_sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      $display("w8 result class_idx=%0d max_count=%0d (expected %0d/%0d)",
               u_if8.class_idx, u_if8.max_count, e.idx, e.cnt);
      check_val("w8_class_idx", u_if8.class_idx, e.idx);
      check_val("w8_max_count", u_if8.max_count, e.cnt);
    end
    u_if8.out_ready = 1'b1;
    @(negedge clk);
    u_if8.out_ready = 1'b0;
    check_val("w8_idle_busy", u_if8.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
